pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage ARM core. It detects register data hazards for the instruction in ID, suppresses stalls while a taken branch flushes the pipe, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It sits beside the ID stage and drives the ID-stage `hazard` input, the IF/PC and pipeline-register freeze controls, and the branch flush. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
Parameters:
- `FWD_EN`, default 1: 1 means a forwarding unit exists, so only load-use hazards stall; 0 means every RAW dependency on EXE or MEM stalls.
- `TIMEOUT`, default 64: consecutive memory-wait cycles before HALT; 0 disables the timeout.
- `CNT_W`, default 16: width of `stall_cnt`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `src1`, `src2` in 4: ID source registers.
- `two_src` in 1: `src2` is a real operand.
- `exe_dest` in 4, `exe_wb_en` in 1, `exe_mem_r_en` in 1: ID/EXE register contents.
- `mem_dest` in 4, `mem_wb_en` in 1: EXE/MEM register contents.
- `branch_taken` in 1: branch resolved taken in EXE.
- `mem_req` in 1: MEM stage holds a load or store.
- `mem_ready` in 1: data memory completes the access this cycle.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.
- `hazard` out 1: to ID; zeroes control bits and inserts a bubble.
- `freeze_if` out 1: hold the PC and IF/ID register.
- `freeze_all` out 1: hold every pipeline register and the PC.
- `flush` out 1: clear IF/ID and ID/EXE.
- `mem_err` out 1: sticky timeout flag.
- `stall_cnt` out `CNT_W`: number of stalled cycles.

## Operation
- Raw hazard, combinational, computed by the sub-module.
  - `m1` = `exe_wb_en` & (`exe_dest`==`src1`).
  - `m2` = `two_src` & `exe_wb_en` & (`exe_dest`==`src2`).
  - `FWD_EN`=1: `raw` = `exe_mem_r_en` & (`m1` | `m2`).
  - `FWD_EN`=0: `raw` = `m1` | `m2` | the same two terms built from `mem_dest`/`mem_wb_en`.
- States: RUN, MEM_WAIT, HALT. Encoding is 2 bits.
- `memstall` = (state≠HALT) & `mem_req` & ~`mem_ready`.
- `freeze_all` = `memstall` | (state==HALT).
- `flush` = `branch_taken` & ~`freeze_all`.
- `hazard` = `raw` & ~`branch_taken` & ~`freeze_all`. Flush beats the data stall; the frozen pipe beats both.
- `freeze_if` = `hazard` | `freeze_all`.
- Transitions:
  - RUN→MEM_WAIT on `memstall`.
  - MEM_WAIT→RUN when `mem_ready`=1, or when `mem_req` drops.
  - MEM_WAIT→HALT when `memstall` holds and `wait_cnt`==`TIMEOUT`-1 (only when `TIMEOUT`≠0).
  - HALT is exited only by `rst`.
- `wait_cnt` counts consecutive `memstall` cycles. It is cleared whenever `memstall`=0 and is sized to `$clog2(TIMEOUT+1)`.
- `mem_err` is set on entry to HALT and cleared only by `rst`.
- `stall_cnt` increments on every cycle with `freeze_if`=1 and saturates at all-ones.
  - `cnt_clr` has priority over increment, so the counter reads 0 in the next cycle.

## Timing
- `hazard`, `freeze_if`, `freeze_all` and `flush` are Mealy outputs with zero latency, valid in the same cycle as their inputs.
- A load-use stall lasts exactly 1 cycle: after the bubble, `exe_mem_r_en` is 0.
- Memory wait with `mem_ready` arriving N cycles after `mem_req`: `freeze_all` is high for N cycles and low in the cycle `mem_ready`=1.
- `mem_ready`=1 in the same cycle as `mem_req`: no stall, and the state stays RUN.
- Timeout: with `mem_ready` held low, `freeze_all` is high for `TIMEOUT` cycles. HALT and `mem_err`=1 follow at the next edge, and `freeze_all` stays 1 from then on.
- Reset values, including asynchronous reset in mid-wait: state RUN, `wait_cnt`=0, `stall_cnt`=0, `mem_err`=0. Combinational outputs then follow their inputs with state=RUN.

## Structure
- Shared package/header:
  - state localparams `ST_RUN`=0, `ST_MEM_WAIT`=1, `ST_HALT`=2;
  - the register-index width (4).
- Sub-module `hazard_detect`: purely combinational `raw` computation, parameterised by `FWD_EN`. It is reusable by a future forwarding unit.
- The top level holds the FSM, `wait_cnt`, `stall_cnt` and the output logic.

## Test plan
- Load-use: `FWD_EN`=1, `exe_mem_r_en`=1, `exe_wb_en`=1, `exe_dest`=3, `src1`=3. Required: `hazard`=`freeze_if`=1 for 1 cycle, `stall_cnt`=1.
- No-forward RAW: `FWD_EN`=0, `mem_wb_en`=1, `mem_dest`=5, `src2`=5, `two_src`=1. Required: `hazard`=1. With `two_src`=0: `hazard`=0.
- Branch vs hazard: `branch_taken`=1 together with a load-use match. Required: `flush`=1, `hazard`=0, `freeze_if`=0.
- Memory wait: `mem_req`=1 and `mem_ready`=0 for 3 cycles, then 1. Required: `freeze_all`=1 for exactly 3 cycles, `flush` masked during them, state back to RUN.
- Timeout: `TIMEOUT`=8, `mem_ready` held 0. Required: `freeze_all` for 8 cycles, then HALT, `mem_err`=1 and persistent. Asserting `rst` returns all outputs to their reset values.
- Counter: `CNT_W`=4, force 20 stall cycles. Required: `stall_cnt` saturates at 15. `cnt_clr` with a simultaneous stall gives 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// State encodings are exported so a register-file view can decode them.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 4;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    typedef enum logic [1:0] {
        StRun     = ST_RUN,
        StMemWait = ST_MEM_WAIT,
        StHalt    = ST_HALT
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// master = pipeline stages, slave = controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;
    logic             hazard;
    logic             freeze_if;
    logic             freeze_all;
    logic             flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clr,
        input  hazard, freeze_if, freeze_all, flush, mem_err, stall_cnt
    );

    modport slave (
        input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, cnt_clr,
        output hazard, freeze_if, freeze_all, flush, mem_err, stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Purely combinational RAW dependency check for the instruction in ID.
// With forwarding only a load in EXE can stall; without it any EXE/MEM writer stalls.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             two_src_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_r_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_wb_en_i,
    output logic             raw_o
);

    logic exe_m1, exe_m2, mem_m1, mem_m2;
    logic raw_fwd, raw_nofwd;

    always_comb begin
        exe_m1    = exe_wb_en_i && (exe_dest_i == src1_i);
        exe_m2    = two_src_i && exe_wb_en_i && (exe_dest_i == src2_i);
        mem_m1    = mem_wb_en_i && (mem_dest_i == src1_i);
        mem_m2    = two_src_i && mem_wb_en_i && (mem_dest_i == src2_i);
        raw_fwd   = exe_mem_r_en_i && (exe_m1 || exe_m2);
        raw_nofwd = exe_m1 || exe_m2 || mem_m1 || mem_m2;
        raw_o     = FWD_EN ? raw_fwd : raw_nofwd;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: data-hazard bubbles, branch flush, memory-wait freeze,
// timeout HALT with sticky error, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit          FWD_EN  = 1'b1,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned       WaitW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WaitW-1:0]  WaitLast = (TIMEOUT > 0) ? WaitW'(TIMEOUT - 1) : '0;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               raw, memstall, timeout_hit;
    logic               hazard, freeze_if, freeze_all, flush;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .src1_i         (bus.src1),
        .src2_i         (bus.src2),
        .two_src_i      (bus.two_src),
        .exe_dest_i     (bus.exe_dest),
        .exe_wb_en_i    (bus.exe_wb_en),
        .exe_mem_r_en_i (bus.exe_mem_r_en),
        .mem_dest_i     (bus.mem_dest),
        .mem_wb_en_i    (bus.mem_wb_en),
        .raw_o          (raw)
    );

    // Priority: frozen pipe > branch flush > data stall.
    always_comb begin
        memstall    = (state_q != StHalt) && bus.mem_req && !bus.mem_ready;
        freeze_all  = memstall || (state_q == StHalt);
        flush       = bus.branch_taken && !freeze_all;
        hazard      = raw && !bus.branch_taken && !freeze_all;
        freeze_if   = hazard || freeze_all;
        timeout_hit = (TIMEOUT != 0) && memstall && (wait_cnt_q == WaitLast);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (timeout_hit)   state_d = StHalt;
                else if (memstall) state_d = StMemWait;
            end
            StMemWait: begin
                if (timeout_hit)                           state_d = StHalt;
                else if (bus.mem_ready || !bus.mem_req)    state_d = StRun;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase

        wait_cnt_d = '0;
        if (memstall) begin
            wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
        end

        mem_err_d = mem_err_q || ((state_d == StHalt) && (state_q != StHalt));

        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
        end else if (freeze_if && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus.hazard     = hazard;
    assign bus.freeze_if  = freeze_if;
    assign bus.freeze_all = freeze_all;
    assign bus.flush      = flush;
    assign bus.mem_err    = mem_err_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: instance A has forwarding, TIMEOUT=8, 4-bit counter;
// instance B has no forwarding and default timeout/counter width.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(4))  ia ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) ib ();

    pipeline_hazard_ctrl #(
        .FWD_EN  (1'b1),
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    pipeline_hazard_ctrl #(
        .FWD_EN  (1'b0),
        .TIMEOUT (64),
        .CNT_W   (16)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ia.src1 = '0; ia.src2 = '0; ia.two_src = 1'b0;
        ia.exe_dest = '0; ia.exe_wb_en = 1'b0; ia.exe_mem_r_en = 1'b0;
        ia.mem_dest = '0; ia.mem_wb_en = 1'b0; ia.branch_taken = 1'b0;
        ia.mem_req = 1'b0; ia.mem_ready = 1'b0; ia.cnt_clr = 1'b0;
    endtask

    task automatic idle_b();
        ib.src1 = '0; ib.src2 = '0; ib.two_src = 1'b0;
        ib.exe_dest = '0; ib.exe_wb_en = 1'b0; ib.exe_mem_r_en = 1'b0;
        ib.mem_dest = '0; ib.mem_wb_en = 1'b0; ib.branch_taken = 1'b0;
        ib.mem_req = 1'b0; ib.mem_ready = 1'b0; ib.cnt_clr = 1'b0;
    endtask

    task automatic load_use_a();
        ia.exe_mem_r_en = 1'b1; ia.exe_wb_en = 1'b1; ia.exe_dest = 4'd3; ia.src1 = 4'd3;
    endtask

    initial begin
        idle_a();
        idle_b();
        #1;
        check("rst_stall_cnt", 32'(ia.stall_cnt), 32'd0);
        check("rst_mem_err", 32'(ia.mem_err), 32'd0);
        check("rst_freeze_all", 32'(ia.freeze_all), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Load-use with forwarding: one bubble cycle
        load_use_a();
        #1;
        check("lu_hazard", 32'(ia.hazard), 32'd1);
        check("lu_freeze_if", 32'(ia.freeze_if), 32'd1);
        check("lu_freeze_all", 32'(ia.freeze_all), 32'd0);
        tick();
        ia.exe_mem_r_en = 1'b0; ia.exe_wb_en = 1'b0;
        #1;
        check("lu_bubble_hazard", 32'(ia.hazard), 32'd0);
        check("lu_stall_cnt", 32'(ia.stall_cnt), 32'd1);

        // Forwarded ALU result: no stall; src2 ignored unless two_src
        ia.exe_wb_en = 1'b1; ia.exe_dest = 4'd3;
        #1;
        check("fwd_alu_no_hazard", 32'(ia.hazard), 32'd0);
        ia.exe_mem_r_en = 1'b1; ia.exe_dest = 4'd7; ia.src1 = 4'd1; ia.src2 = 4'd7;
        #1;
        check("src2_unused", 32'(ia.hazard), 32'd0);
        ia.two_src = 1'b1;
        #1;
        check("src2_used", 32'(ia.hazard), 32'd1);
        idle_a();

        // No-forward RAW on B
        ib.mem_wb_en = 1'b1; ib.mem_dest = 4'd5; ib.src2 = 4'd5; ib.src1 = 4'd0; ib.two_src = 1'b1;
        #1;
        check("nofwd_mem_src2", 32'(ib.hazard), 32'd1);
        ib.two_src = 1'b0;
        #1;
        check("nofwd_two_src0", 32'(ib.hazard), 32'd0);
        idle_b();
        ib.exe_wb_en = 1'b1; ib.exe_dest = 4'd2; ib.src1 = 4'd2;
        #1;
        check("nofwd_exe_alu", 32'(ib.hazard), 32'd1);
        tick();
        tick();
        idle_b();
        #1;
        check("b_stall_cnt", 32'(ib.stall_cnt), 32'd2);

        // Branch beats load-use
        load_use_a();
        ia.branch_taken = 1'b1;
        #1;
        check("br_flush", 32'(ia.flush), 32'd1);
        check("br_hazard", 32'(ia.hazard), 32'd0);
        check("br_freeze_if", 32'(ia.freeze_if), 32'd0);
        tick();
        idle_a();
        #1;
        check("br_stall_cnt", 32'(ia.stall_cnt), 32'd1);

        // Memory wait 3 cycles, flush masked meanwhile
        ia.mem_req = 1'b1; ia.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_freeze_all", 32'(ia.freeze_all), 32'd1);
            check("mw_flush_masked", 32'(ia.flush), 32'd0);
            tick();
        end
        ia.mem_ready = 1'b1;
        #1;
        check("mw_ready_freeze", 32'(ia.freeze_all), 32'd0);
        check("mw_ready_flush", 32'(ia.flush), 32'd1);
        tick();
        idle_a();
        #1;
        check("mw_state_run", 32'(dut_a.state_q), 32'(ST_RUN));
        check("mw_stall_cnt", 32'(ia.stall_cnt), 32'd4);

        // Ready in the same cycle as request: no stall
        ia.mem_req = 1'b1; ia.mem_ready = 1'b1;
        #1;
        check("mr_same_freeze", 32'(ia.freeze_all), 32'd0);
        tick();
        check("mr_same_state", 32'(dut_a.state_q), 32'(ST_RUN));
        idle_a();

        // Saturating counter, then clear with simultaneous stall
        ia.cnt_clr = 1'b1;
        tick();
        ia.cnt_clr = 1'b0;
        #1;
        check("cnt_cleared", 32'(ia.stall_cnt), 32'd0);
        load_use_a();
        for (int i = 0; i < 20; i++) tick();
        check("cnt_saturate", 32'(ia.stall_cnt), 32'd15);
        ia.cnt_clr = 1'b1;
        tick();
        check("cnt_clr_prio", 32'(ia.stall_cnt), 32'd0);
        ia.cnt_clr = 1'b0;
        tick();
        check("cnt_restart", 32'(ia.stall_cnt), 32'd1);
        idle_a();

        // Timeout after 8 frozen cycles
        ia.mem_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("to_freeze_all", 32'(ia.freeze_all), 32'd1);
            check("to_no_err_yet", 32'(ia.mem_err), 32'd0);
            tick();
        end
        check("to_mem_err", 32'(ia.mem_err), 32'd1);
        check("to_state_halt", 32'(dut_a.state_q), 32'(ST_HALT));
        idle_a();
        load_use_a();
        ia.branch_taken = 1'b1;
        #1;
        check("halt_freeze_all", 32'(ia.freeze_all), 32'd1);
        check("halt_flush", 32'(ia.flush), 32'd0);
        check("halt_hazard", 32'(ia.hazard), 32'd0);
        tick();
        tick();
        check("halt_err_sticky", 32'(ia.mem_err), 32'd1);
        check("halt_state_kept", 32'(dut_a.state_q), 32'(ST_HALT));

        // Asynchronous reset out of HALT, and out of B's mid-wait
        idle_a();
        ib.mem_req = 1'b1;
        tick();
        tick();
        tick();
        check("b_midwait_state", 32'(dut_b.state_q), 32'(ST_MEM_WAIT));
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_err", 32'(ia.mem_err), 32'd0);
        check("arst_stall_cnt", 32'(ia.stall_cnt), 32'd0);
        check("arst_freeze_all", 32'(ia.freeze_all), 32'd0);
        check("arst_state_a", 32'(dut_a.state_q), 32'(ST_RUN));
        check("arst_state_b", 32'(dut_b.state_q), 32'(ST_RUN));
        check("arst_wait_cnt_b", 32'(dut_b.wait_cnt_q), 32'd0);
        check("arst_b_freeze", 32'(ib.freeze_all), 32'd1);
        tick();
        rst = 1'b0;
        idle_b();
        tick();
        check("post_rst_freeze", 32'(ia.freeze_all), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
